// File: rtl/duty_value_display.sv
// duty_value_display: converts each new 16-bit value to 4-digit BCD with a
// sequential double-dabble engine and scans it onto a multiplexed,
// active-low 4-digit 7-segment display.
module duty_value_display #(
    parameter int REFRESH_BITS = 16,
    parameter bit BLANK_LZ     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_in,
    output logic        busy,
    output logic [15:0] bcd,
    output logic        overflow,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    localparam logic [REFRESH_BITS-1:0] CNT_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

    state_t                  state, state_nx;
    logic [15:0]             last_value;
    logic [15:0]             operand;
    logic [31:0]             shreg;
    logic [31:0]             adj;
    logic [3:0]              iter;
    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [1:0]              sel;
    logic [3:0]              digit;
    logic                    blank;

    assign busy = (state != IDLE);

    // 7-segment decode {g,f,e,d,c,b,a}, active low; non-BCD shows blank
    function automatic logic [6:0] seg_map(input logic [3:0] d);
        case (d)
            4'd0:    seg_map = 7'h40;
            4'd1:    seg_map = 7'h79;
            4'd2:    seg_map = 7'h24;
            4'd3:    seg_map = 7'h30;
            4'd4:    seg_map = 7'h19;
            4'd5:    seg_map = 7'h12;
            4'd6:    seg_map = 7'h02;
            4'd7:    seg_map = 7'h78;
            4'd8:    seg_map = 7'h00;
            4'd9:    seg_map = 7'h10;
            default: seg_map = 7'h7F;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic: a change in value_in starts a conversion, only from IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (value_in != last_value) state_nx = CONVERT;
            CONVERT: if (iter == 4'd15)          state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Double-dabble add-3 correction on every BCD nibble before the shift
    always_comb begin
        adj = shreg;
        for (int i = 0; i < 4; i++) begin
            if (shreg[16 + 4*i +: 4] >= 4'd5)
                adj[16 + 4*i +: 4] = shreg[16 + 4*i +: 4] + 4'd3;
        end
    end

    // Conversion datapath and result commit (saturates above 9999)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_value <= 16'h0;
            operand    <= 16'h0;
            shreg      <= 32'h0;
            iter       <= 4'd0;
            bcd        <= 16'h0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (value_in != last_value) begin
                        last_value <= value_in;
                        operand    <= value_in;
                        shreg      <= {16'h0, value_in};
                        iter       <= 4'd0;
                    end
                end
                CONVERT: begin
                    shreg <= {adj[30:0], 1'b0};
                    iter  <= iter + 4'd1;
                end
                DONE: begin
                    if (operand > 16'd9999) begin
                        bcd      <= 16'h9999;
                        overflow <= 1'b1;
                    end else begin
                        bcd      <= shreg[31:16];
                        overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Free-running refresh counter; top two bits pick the digit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) refresh_cnt <= '0;
        else       refresh_cnt <= refresh_cnt + CNT_ONE;
    end

    assign sel   = refresh_cnt[REFRESH_BITS-1 -: 2];
    assign digit = bcd[4*sel +: 4];

    // Leading-zero blanking: a digit blanks when it and all higher digits are zero
    always_comb begin
        blank = 1'b0;
        case (sel)
            2'd3: blank = (bcd[15:12] == 4'h0);
            2'd2: blank = (bcd[15:8]  == 8'h0);
            2'd1: blank = (bcd[15:4]  == 12'h0);
            default: blank = 1'b0;
        endcase
        blank = blank & BLANK_LZ;
    end

    // Registered display drive; dp flags overflow on the thousands digit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << sel);
            seg <= blank ? 7'h7F : seg_map(digit);
            dp  <= ~((sel == 2'd3) & overflow);
        end
    end

endmodule

// File: tb/tb_duty_value_display.sv
// Bench for duty_value_display: scoreboard of expected commits, per-scenario
// tasks with inline checks of conversion results, latency and display scan.
module tb_duty_value_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value_in, value_in2;
    logic        busy, busy2;
    logic [15:0] bcd, bcd2;
    logic        overflow, overflow2;
    logic [3:0]  an, an2;
    logic [6:0]  seg, seg2;
    logic        dp, dp2;

    int checks = 0;
    int failures = 0;
    logic [16:0] sb_q[$];   // {overflow, bcd}
    bit saw200 = 1'b0;

    always #5 clk = ~clk;

    duty_value_display #(.REFRESH_BITS(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .reset(reset), .value_in(value_in), .busy(busy), .bcd(bcd),
        .overflow(overflow), .an(an), .seg(seg), .dp(dp));

    duty_value_display #(.REFRESH_BITS(4), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .value_in(value_in2), .busy(busy2), .bcd(bcd2),
        .overflow(overflow2), .an(an2), .seg(seg2), .dp(dp2));

    always @(negedge clk) if (bcd == 16'h0200) saw200 = 1'b1;

    function automatic logic [16:0] model(input int v);
        int s;
        logic [16:0] r;
        s = (v > 9999) ? 9999 : v;
        r[3:0]   = 4'(s % 10);
        r[7:4]   = 4'((s / 10) % 10);
        r[11:8]  = 4'((s / 100) % 10);
        r[15:12] = 4'((s / 1000) % 10);
        r[16]    = (v > 9999);
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] b, input int i, input bit blz);
        logic [6:0] tab [0:9];
        logic [3:0] d;
        bit all_zero;
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        all_zero = 1'b1;
        for (int j = i; j < 4; j++) if (b[4*j +: 4] != 4'h0) all_zero = 1'b0;
        if (blz && i > 0 && all_zero) return 7'h7F;
        d = b[4*i +: 4];
        return (d > 4'd9) ? 7'h7F : tab[d];
    endfunction

    function automatic int an_idx(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // Waits (bounded) for a conversion on the main DUT; returns busy-high cycles
    task automatic run_conv(output int cycles);
        cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) cycles++;
            else if (cycles > 0) break;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; value_in = 16'h0; value_in2 = 16'h0;
        @(negedge clk);
        checks++;
        if ({an, seg, dp, busy, bcd, overflow} !== {4'b1111, 7'h7F, 1'b1, 1'b0, 16'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: an=%b seg=%h dp=%b busy=%b bcd=%h ovf=%b", an, seg, dp, busy, bcd, overflow);
        end
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            checks++;
            if (an_idx(an) != ((k - 1) >> 2) % 4 || busy !== 1'b0 || bcd !== 16'h0) begin
                failures++;
                $display("FAIL reset_scan k=%0d: an=%b busy=%b bcd=%h, want idx %0d busy 0 bcd 0", k, an, busy, bcd, ((k - 1) >> 2) % 4);
            end
            checks++;
            if (an_idx(an) >= 0 && seg !== ((an_idx(an) == 0) ? 7'h40 : 7'h7F)) begin
                failures++;
                $display("FAIL reset_seg: an=%b seg=%h", an, seg);
            end
        end
    endtask

    task automatic test_convert_255;
        int n;
        logic [16:0] e;
        value_in = 16'd255; sb_q.push_back(model(255));
        run_conv(n);
        checks++;
        if (n != 17) begin failures++; $display("FAIL busy_len_255: got %0d want 17", n); end
        e = sb_q.pop_front();
        checks++;
        if ({overflow, bcd} !== e) begin failures++; $display("FAIL bcd_255: got %h want %h", {overflow, bcd}, e); end
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if (an_idx(an) < 0 || seg !== exp_seg(e[15:0], an_idx(an), 1'b1) || dp !== 1'b1) begin
                failures++;
                $display("FAIL disp_255: an=%b seg=%h dp=%b", an, seg, dp);
            end
        end
    endtask

    task automatic test_overflow;
        int n;
        logic [16:0] e;
        value_in = 16'd12345; sb_q.push_back(model(12345));
        run_conv(n);
        e = sb_q.pop_front();
        checks++;
        if ({overflow, bcd} !== e) begin failures++; $display("FAIL bcd_12345: got %h want %h", {overflow, bcd}, e); end
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if (dp !== (an == 4'b0111 ? 1'b0 : 1'b1) || an_idx(an) < 0 || seg !== 7'h10) begin
                failures++;
                $display("FAIL dp_ovf: an=%b dp=%b seg=%h", an, dp, seg);
            end
        end
        value_in = 16'd9999; sb_q.push_back(model(9999));
        run_conv(n);
        e = sb_q.pop_front();
        checks++;
        if ({overflow, bcd} !== e) begin failures++; $display("FAIL bcd_9999: got %h want %h", {overflow, bcd}, e); end
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if (dp !== 1'b1) begin failures++; $display("FAIL dp_9999: an=%b dp=%b want 1", an, dp); end
        end
    endtask

    task automatic test_back_to_back;
        int cnt, n;
        logic [16:0] e;
        bit done;
        value_in = 16'd100; sb_q.push_back(model(100));
        cnt = 0; done = 1'b0;
        for (int i = 1; i < 60 && !done; i++) begin
            @(negedge clk);
            if (i == 5)  value_in = 16'd200;
            if (i == 10) begin value_in = 16'd77; sb_q.push_back(model(77)); end
            if (busy) cnt++;
            else if (cnt > 0) done = 1'b1;
        end
        e = sb_q.pop_front();
        checks++;
        if (!done || {overflow, bcd} !== e) begin
            failures++; $display("FAIL commit_100: got %h want %h done=%b", {overflow, bcd}, e, done);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL retrigger: busy=%b want 1", busy); end
        run_conv(n);
        e = sb_q.pop_front();
        checks++;
        if ({overflow, bcd} !== e) begin failures++; $display("FAIL commit_77: got %h want %h", {overflow, bcd}, e); end
        checks++;
        if (saw200 !== 1'b0) begin failures++; $display("FAIL dropped_200: saw200=%b want 0", saw200); end
    endtask

    task automatic test_reset_mid;
        int n;
        logic [16:0] e;
        value_in = 16'd4660;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || bcd !== 16'h0 || an !== 4'b1111) begin
            failures++; $display("FAIL reset_mid: busy=%b bcd=%h an=%b want 0 0000 1111", busy, bcd, an);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bcd !== 16'h0) begin failures++; $display("FAIL reset_hold: bcd=%h want 0000", bcd); end
        reset = 1'b0; sb_q.push_back(model(4660));
        run_conv(n);
        checks++;
        if (n != 17) begin failures++; $display("FAIL busy_len_4660: got %0d want 17", n); end
        e = sb_q.pop_front();
        checks++;
        if ({overflow, bcd} !== e) begin failures++; $display("FAIL bcd_4660: got %h want %h", {overflow, bcd}, e); end
    endtask

    task automatic test_no_blank;
        int cnt;
        bit done;
        logic [16:0] e;
        value_in2 = 16'd7; e = model(7);
        cnt = 0; done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (busy2) cnt++;
            else if (cnt > 0) done = 1'b1;
        end
        checks++;
        if (!done || {overflow2, bcd2} !== e) begin
            failures++; $display("FAIL bcd_nb_7: got %h want %h done=%b", {overflow2, bcd2}, e, done);
        end
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if (an_idx(an2) < 0 || seg2 !== exp_seg(e[15:0], an_idx(an2), 1'b0)) begin
                failures++; $display("FAIL disp_nb: an=%b seg=%h", an2, seg2);
            end
        end
    endtask

    initial begin
        test_reset;
        test_convert_255;
        test_overflow;
        test_back_to_back;
        test_reset_mid;
        test_no_blank;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
